// File: rtl/dma_pkg.sv
// Shared types for the DMA I/O port: FSM states, transfer direction and data width.
package dma_pkg;

  localparam int DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef enum logic {
    RX = 1'b0,
    TX = 1'b1
  } dir_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on head_o without a pop.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module dma_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic [DW-1:0]          wdata_i,
  input  logic                   pop_i,
  output logic [DW-1:0]          head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == DEPTH_C);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Forced to zero when empty so the head never shows stale or unwritten storage.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/dma_io_port.sv
// Device-side DMA port: RX FIFO drained by IOR, TX FIFO filled by IOW, DREQ/RDY handshake.
// Optional idle flush of a partially filled RX FIFO is enabled by DMA_IO_PORT_FLUSH_EN.
module dma_io_port
  import dma_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int THRESH = 4
`ifdef DMA_IO_PORT_FLUSH_EN
  ,
  parameter int FLUSH_CYC = 32
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          DREQ,
  input  logic          DACK,
  input  logic          IOR,
  input  logic          IOW,
  input  logic          EOP,
  output logic          RDY,
  output logic [DW-1:0] Data_out,
  input  logic [DW-1:0] Data_in,
  input  logic          Dev_wr,
  input  logic [DW-1:0] Dev_wdata,
  output logic          Dev_full,
  input  logic          Dev_rd,
  output logic [DW-1:0] Dev_rdata,
  output logic          Dev_empty,
  output logic          Ovf
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C = CW'(THRESH);

  state_e        state_q, state_d;
  dir_e          dir_q, dir_d;
  logic          ovf_q, ovf_d;
  logic          in_xfer;
  logic          rx_pop, rx_full, rx_empty;
  logic          tx_push, tx_full, tx_empty;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_req, tx_req, flush_hit;

  assign in_xfer = (state_q == XFER);
  assign rx_pop  = in_xfer && (dir_q == RX) && DACK && IOR;
  // A write into a full TX is held off with RDY=0, so it must not land in the FIFO.
  assign tx_push = in_xfer && (dir_q == TX) && DACK && IOW && !tx_full;

  assign RDY = !((DACK && IOR && (dir_q == RX) && rx_empty) ||
                 (DACK && IOW && (dir_q == TX) && tx_full));

  assign rx_req = (rx_count >= THRESH_C);
  assign tx_req = ((DEPTH_C - tx_count) >= THRESH_C);

  assign Dev_full  = rx_full;
  assign Dev_empty = tx_empty;
  assign Ovf       = ovf_q;

  // A full RX is never empty, so any IOR strobe in RX transfer frees the slot.
  assign ovf_d = ovf_q || (Dev_wr && rx_full && !rx_pop);

  dma_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (Dev_wr),
    .wdata_i (Dev_wdata),
    .pop_i   (rx_pop),
    .head_o  (Data_out),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  dma_sync_fifo #(.DEPTH(DEPTH), .DW(DW)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (RST),
    .push_i  (tx_push),
    .wdata_i (Data_in),
    .pop_i   (Dev_rd),
    .head_o  (Dev_rdata),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

`ifdef DMA_IO_PORT_FLUSH_EN
  localparam int FW = $clog2(FLUSH_CYC + 1);

  logic [FW-1:0] idle_cnt_q, idle_cnt_d;
  logic          idle_counting;

  assign idle_counting = (state_q == IDLE) && (rx_count != '0) && !rx_req && !Dev_wr;
  assign flush_hit     = idle_counting && (idle_cnt_q == FW'(FLUSH_CYC - 1));
  assign idle_cnt_d    = (idle_counting && (state_d == IDLE)) ? idle_cnt_q + 1'b1 : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign flush_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    DREQ    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_req || flush_hit) begin
          dir_d   = RX;
          state_d = REQ;
        end else if (tx_req) begin
          dir_d   = TX;
          state_d = REQ;
        end
      end
      REQ: begin
        DREQ = 1'b1;
        if (DACK) begin
          state_d = XFER;
        end
      end
      XFER: begin
        DREQ = (dir_q == RX) ? !rx_empty : !tx_full;
        if (EOP || !DACK) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dir_q   <= RX;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_dma_io_port.sv
// Self-checking bench for dma_io_port: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_dma_io_port;

  localparam int DEPTH     = 8;
  localparam int THRESH    = 4;
  localparam int FLUSH_CYC = 32;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       DACK = 1'b0, IOR = 1'b0, IOW = 1'b0, EOP = 1'b0;
  logic       Dev_wr = 1'b0, Dev_rd = 1'b0;
  logic [7:0] Data_in = 8'h00, Dev_wdata = 8'h00;
  logic       DREQ, RDY, Dev_full, Dev_empty, Ovf;
  logic [7:0] Data_out, Dev_rdata;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  dma_io_port dut (
    .CLK       (CLK),
    .RST       (RST),
    .DREQ      (DREQ),
    .DACK      (DACK),
    .IOR       (IOR),
    .IOW       (IOW),
    .EOP       (EOP),
    .RDY       (RDY),
    .Data_out  (Data_out),
    .Data_in   (Data_in),
    .Dev_wr    (Dev_wr),
    .Dev_wdata (Dev_wdata),
    .Dev_full  (Dev_full),
    .Dev_rd    (Dev_rd),
    .Dev_rdata (Dev_rdata),
    .Dev_empty (Dev_empty),
    .Ovf       (Ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFOs as queues, handshake as a phase (0 idle, 1 requesting,
  // 2 transferring, 3 one-cycle cooldown after the transfer ends).
  byte unsigned rx_q[$];
  byte unsigned tx_q[$];
  bit           m_ovf;
  int           m_phase;
  bit           m_dir_tx;
  bit           model_valid = 1'b0;
`ifdef DMA_IO_PORT_FLUSH_EN
  int           m_quiet;
`endif

  task automatic model_step();
    int rxn, txn;
    bit rx_pop_ok, rx_push_ok, tx_push_ok, tx_pop_ok;
    if (RST) begin
      rx_q.delete();
      tx_q.delete();
      m_ovf       = 1'b0;
      m_phase     = 0;
      m_dir_tx    = 1'b0;
      model_valid = 1'b1;
`ifdef DMA_IO_PORT_FLUSH_EN
      m_quiet = 0;
`endif
      return;
    end
    rxn = rx_q.size();
    txn = tx_q.size();
    rx_pop_ok  = (m_phase == 2) && !m_dir_tx && DACK && IOR && (rxn > 0);
    tx_push_ok = (m_phase == 2) && m_dir_tx && DACK && IOW && (txn < DEPTH);
    tx_pop_ok  = Dev_rd && (txn > 0);
    rx_push_ok = Dev_wr && ((rxn < DEPTH) || rx_pop_ok);
    if (Dev_wr && !rx_push_ok) m_ovf = 1'b1;
    if (rx_pop_ok) void'(rx_q.pop_front());
    if (rx_push_ok) rx_q.push_back(Dev_wdata);
    if (tx_pop_ok) void'(tx_q.pop_front());
    if (tx_push_ok) tx_q.push_back(Data_in);
    case (m_phase)
      0: begin
`ifdef DMA_IO_PORT_FLUSH_EN
        if (rxn > 0 && rxn < THRESH && !Dev_wr) m_quiet++;
        else m_quiet = 0;
`endif
        if (rxn >= THRESH) begin
          m_dir_tx = 1'b0;
          m_phase  = 1;
`ifdef DMA_IO_PORT_FLUSH_EN
        end else if (m_quiet == FLUSH_CYC) begin
          m_dir_tx = 1'b0;
          m_phase  = 1;
`endif
        end else if (DEPTH - txn >= THRESH) begin
          m_dir_tx = 1'b1;
          m_phase  = 1;
        end
`ifdef DMA_IO_PORT_FLUSH_EN
        if (m_phase != 0) m_quiet = 0;
`endif
      end
      1: if (DACK) m_phase = 2;
      2: if (EOP || !DACK) m_phase = 3;
      default: m_phase = 0;
    endcase
  endtask

  task automatic compare();
    logic       exp_dreq, exp_rdy;
    logic [7:0] exp_dout, exp_drd;
    int rxn, txn;
    rxn = rx_q.size();
    txn = tx_q.size();
    exp_dreq = (m_phase == 1) ||
               ((m_phase == 2) && (m_dir_tx ? (txn < DEPTH) : (rxn > 0)));
    exp_rdy  = !((DACK && IOR && !m_dir_tx && rxn == 0) ||
                 (DACK && IOW && m_dir_tx && txn == DEPTH));
    exp_dout = (rxn > 0) ? rx_q[0] : 8'h00;
    exp_drd  = (txn > 0) ? tx_q[0] : 8'h00;
    chk("m_DREQ", DREQ, exp_dreq);
    chk("m_RDY", RDY, exp_rdy);
    chk("m_Data_out", Data_out, exp_dout);
    chk("m_Dev_rdata", Dev_rdata, exp_drd);
    chk("m_Dev_full", Dev_full, rxn == DEPTH);
    chk("m_Dev_empty", Dev_empty, txn == 0);
    chk("m_Ovf", Ovf, m_ovf);
  endtask

  initial forever begin
    @(posedge CLK);
    model_step();
  end

  initial forever begin
    @(negedge CLK);
    if (model_valid) compare();
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_dreq(input int budget);
    int n;
    n = 0;
    while (DREQ !== 1'b1 && n < budget) begin
      cyc();
      n++;
    end
    chk("dreq_wait", DREQ, 1'b1);
  endtask

  // Fill TX completely through one DMA write transfer, then return to idle.
  task automatic fill_tx();
    wait_dreq(20);
    DACK = 1'b1;
    cyc();
    IOW = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      Data_in = 8'($urandom);
      cyc();
    end
    IOW = 1'b0;
    chk("tx_full_dreq", DREQ, 1'b0);
    chk("tx_full_empty", Dev_empty, 1'b0);
    DACK = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    int n;
    bit seen;
    byte unsigned rx_bytes[4];
    rx_bytes[0] = 8'h05; rx_bytes[1] = 8'h0A; rx_bytes[2] = 8'h0F; rx_bytes[3] = 8'h14;

    // Reset values
    cyc();
    cyc();
    chk("rst_DREQ", DREQ, 1'b0);
    chk("rst_RDY", RDY, 1'b1);
    chk("rst_Ovf", Ovf, 1'b0);
    chk("rst_Dev_full", Dev_full, 1'b0);
    chk("rst_Dev_empty", Dev_empty, 1'b1);
    chk("rst_Data_out", Data_out, 8'h00);
    chk("rst_Dev_rdata", Dev_rdata, 8'h00);
    RST = 1'b0;

    // TX transfer of three bytes ended by EOP
    wait_dreq(20);
    DACK = 1'b1;
    cyc();
    IOW = 1'b1; Data_in = 8'h91; cyc();
    Data_in = 8'h03; cyc();
    Data_in = 8'h01; EOP = 1'b1; cyc();
    IOW = 1'b0; EOP = 1'b0; DACK = 1'b0;
    chk("done_DREQ", DREQ, 1'b0);
    cyc();
    chk("after_done_DREQ", DREQ, 1'b0);
    chk("tx_head0", Dev_rdata, 8'h91);
    Dev_rd = 1'b1; cyc();
    chk("tx_head1", Dev_rdata, 8'h03);
    cyc();
    chk("tx_head2", Dev_rdata, 8'h01);
    cyc();
    Dev_rd = 1'b0;
    chk("tx_drained", Dev_empty, 1'b1);
    chk("tx_drained_data", Dev_rdata, 8'h00);

    // Keep TX full so the RX scenarios are not pre-empted by TX requests
    fill_tx();

    // RX transfer of four bytes
    for (int i = 0; i < 4; i++) begin
      Dev_wr = 1'b1; Dev_wdata = rx_bytes[i]; cyc();
    end
    Dev_wr = 1'b0;
    wait_dreq(5);
    DACK = 1'b1;
    cyc();
    chk("rx_xfer_DREQ", DREQ, 1'b1);
    IOR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("rx_data", Data_out, rx_bytes[i]);
      cyc();
    end
    IOR = 1'b0;
    chk("rx_empty_DREQ", DREQ, 1'b0);

    // Wait state on an empty RX, released by a device push
    Dev_wr = 1'b1; Dev_wdata = 8'h21; cyc();
    Dev_wr = 1'b0;
    IOR = 1'b1;
    chk("ws_rdy_first", RDY, 1'b1);
    chk("ws_data_first", Data_out, 8'h21);
    cyc();
    chk("ws_rdy_stall", RDY, 1'b0);
    Dev_wr = 1'b1; Dev_wdata = 8'h33; cyc();
    Dev_wr = 1'b0;
    chk("ws_rdy_release", RDY, 1'b1);
    chk("ws_data_release", Data_out, 8'h33);
    cyc();
    IOR = 1'b0;
    chk("ws_consumed", Data_out, 8'h00);
    DACK = 1'b0;
    cyc();
    cyc();

    // Overflow, then simultaneous push/pop on a full RX
    for (int i = 0; i < DEPTH; i++) begin
      Dev_wr = 1'b1; Dev_wdata = 8'(8'h40 + i); cyc();
    end
    chk("ovf_full", Dev_full, 1'b1);
    chk("ovf_not_yet", Ovf, 1'b0);
    Dev_wdata = 8'hEE; cyc();
    Dev_wr = 1'b0;
    chk("ovf_set", Ovf, 1'b1);
    chk("ovf_head", Data_out, 8'h40);
    DACK = 1'b1;
    cyc();
    Dev_wr = 1'b1; Dev_wdata = 8'h5A; IOR = 1'b1; cyc();
    Dev_wr = 1'b0;
    chk("simul_full", Dev_full, 1'b1);
    chk("simul_head", Data_out, 8'h41);
    cyc();
    chk("second_pop_head", Data_out, 8'h42);

    // Reset in the middle of the transfer
    RST = 1'b1; IOR = 1'b0; DACK = 1'b0;
    cyc();
    RST = 1'b0;
    chk("mrst_DREQ", DREQ, 1'b0);
    chk("mrst_Data_out", Data_out, 8'h00);
    chk("mrst_Dev_full", Dev_full, 1'b0);
    chk("mrst_Ovf", Ovf, 1'b0);
    chk("mrst_Dev_empty", Dev_empty, 1'b1);

    // Partial RX fill with TX full: flush request timing (or silence)
    fill_tx();
    Dev_wr = 1'b1; Dev_wdata = 8'h7E; cyc();
    Dev_wr = 1'b0;
`ifdef DMA_IO_PORT_FLUSH_EN
    n = 0;
    while (DREQ !== 1'b1 && n < 200) begin
      cyc();
      n++;
    end
    chk("flush_delay", n, FLUSH_CYC);
`else
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (DREQ !== 1'b0) seen = 1'b1;
    end
    chk("no_flush_DREQ", seen, 1'b0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) DACK = ~DACK;
      IOR       = ($urandom_range(1) == 0);
      IOW       = ($urandom_range(1) == 0);
      EOP       = ($urandom_range(19) == 0);
      Dev_wr    = ($urandom_range(1) == 0);
      Dev_rd    = ($urandom_range(2) == 0);
      Dev_wdata = 8'($urandom);
      Data_in   = 8'($urandom);
      RST       = ($urandom_range(399) == 0);
      cyc();
    end
    RST = 1'b0; DACK = 1'b0; IOR = 1'b0; IOW = 1'b0; EOP = 1'b0;
    Dev_wr = 1'b0; Dev_rd = 1'b0;
    cyc();
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
